// File: rtl/axi_stream_register_slice.sv
// Two-entry AXI-Stream register slice (skid buffer): every m_* output and s_tready
// come straight from flops, so no combinational path crosses the slice.
module axi_stream_register_slice #(
  parameter  int byte_width = 4,
  parameter  int keep_width = 0,
  parameter  int id_width   = 0,
  parameter  int dest_width = 0,
  parameter  int user_width = 0,
  localparam int DW  = (byte_width > 0) ? 8 * byte_width : 1,
  localparam int SW  = (byte_width > 0) ? byte_width : 1,
  localparam int KW  = (byte_width > 0) ? byte_width : keep_width + 1,
  localparam int IW  = (id_width   > 0) ? id_width   : 1,
  localparam int DEW = (dest_width > 0) ? dest_width : 1,
  localparam int UW  = (user_width > 0) ? user_width : 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic [DW-1:0]  s_tdata,
  input  logic [SW-1:0]  s_tstrb,
  input  logic [KW-1:0]  s_tkeep,
  input  logic           s_tlast,
  input  logic [IW-1:0]  s_tid,
  input  logic [DEW-1:0] s_tdest,
  input  logic [UW-1:0]  s_tuser,
  output logic           m_tvalid,
  input  logic           m_tready,
  output logic [DW-1:0]  m_tdata,
  output logic [SW-1:0]  m_tstrb,
  output logic [KW-1:0]  m_tkeep,
  output logic           m_tlast,
  output logic [IW-1:0]  m_tid,
  output logic [DEW-1:0] m_tdest,
  output logic [UW-1:0]  m_tuser,
  output logic [1:0]     dbg_state
);

  localparam int PW = DW + SW + KW + 1 + IW + DEW + UW;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   out_pl;
  logic [PW-1:0]   skid_pl;
  logic [PW-1:0]   in_pl;
  logic            acc;
  logic            pop;

  // Omitted fields are forced to zero at the input so they reach m_* as constant 0.
  logic [DW-1:0]  in_data;
  logic [SW-1:0]  in_strb;
  logic [IW-1:0]  in_id;
  logic [DEW-1:0] in_dest;
  logic [UW-1:0]  in_user;

  assign in_data = (byte_width > 0) ? s_tdata : '0;
  assign in_strb = (byte_width > 0) ? s_tstrb : '0;
  assign in_id   = (id_width   > 0) ? s_tid   : '0;
  assign in_dest = (dest_width > 0) ? s_tdest : '0;
  assign in_user = (user_width > 0) ? s_tuser : '0;
  assign in_pl   = {in_data, in_strb, s_tkeep, s_tlast, in_id, in_dest, in_user};

  assign acc = s_tvalid && s_tready;
  assign pop = m_tvalid && m_tready;

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // valid never drops and payload never changes until that edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_EMPTY;
      m_tvalid <= 1'b0;
      s_tready <= 1'b0;
      out_pl   <= '0;
      skid_pl  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          s_tready <= 1'b1;
          if (acc) begin
            out_pl   <= in_pl;
            m_tvalid <= 1'b1;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            out_pl <= in_pl;
          end else if (acc) begin
            skid_pl  <= in_pl;
            s_tready <= 1'b0;
            state    <= ST_FULL;
          end else if (pop) begin
            m_tvalid <= 1'b0;
            state    <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            out_pl   <= skid_pl;
            s_tready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          m_tvalid <= 1'b0;
          s_tready <= 1'b0;
          state    <= ST_EMPTY;
        end
      endcase
    end
  end

  assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = out_pl;
  assign dbg_state = state;

endmodule

// File: tb/tb_axi_stream_register_slice.sv
// Bench for axi_stream_register_slice: directed throughput/backpressure/reset cases,
// a randomised scoreboard run, and a byte_width=0 build for keep/last pass-through.
module tb_axi_stream_register_slice;

  localparam int W = 45;  // {tdata32, tstrb4, tkeep4, tlast, tid4}

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_tvalid, s_tready, m_tvalid, m_tready;
  logic [31:0] s_tdata, m_tdata;
  logic [3:0]  s_tstrb, m_tstrb, s_tkeep, m_tkeep;
  logic        s_tlast, m_tlast;
  logic [3:0]  s_tid, m_tid;
  logic        s_tdest, m_tdest, s_tuser, m_tuser;
  logic [1:0]  dbg_state;

  logic        b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tready;
  logic        b_s_tdata, b_m_tdata, b_s_tstrb, b_m_tstrb;
  logic [1:0]  b_s_tkeep, b_m_tkeep;
  logic        b_s_tlast, b_m_tlast;
  logic        b_s_tid, b_m_tid, b_s_tdest, b_m_tdest, b_s_tuser, b_m_tuser;
  logic [1:0]  b_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  axi_stream_register_slice #(.byte_width(4), .id_width(4)) dut (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .dbg_state(dbg_state)
  );

  axi_stream_register_slice #(.byte_width(0), .keep_width(1)) dut_nb (
    .clk(clk), .resetn(resetn),
    .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tdata(b_s_tdata), .s_tstrb(b_s_tstrb),
    .s_tkeep(b_s_tkeep), .s_tlast(b_s_tlast), .s_tid(b_s_tid), .s_tdest(b_s_tdest),
    .s_tuser(b_s_tuser),
    .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tdata(b_m_tdata), .m_tstrb(b_m_tstrb),
    .m_tkeep(b_m_tkeep), .m_tlast(b_m_tlast), .m_tid(b_m_tid), .m_tdest(b_m_tdest),
    .m_tuser(b_m_tuser), .dbg_state(b_dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard + downstream protocol checks, sampled mid-cycle
  initial begin
    logic          stall_prev;
    logic [W-1:0]  prev_pl, cur_pl;
    stall_prev = 1'b0;
    prev_pl    = '0;
    forever begin
      @(negedge clk);
      cur_pl = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid};
      if (!resetn) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", 64'(m_tvalid), 64'd1);
          check("hold_payload", 64'(cur_pl), 64'(prev_pl));
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) check("pop_unexpected", 64'd1, 64'd0);
          else check("sb_beat", 64'(cur_pl), 64'(exp_q.pop_front()));
        end
        if (s_tvalid && s_tready)
          exp_q.push_back({s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid});
        stall_prev = m_tvalid && !m_tready;
        prev_pl    = cur_pl;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] t1v [3];
    int          nbeats, cyc;
    logic        took, done;
    t1v = '{32'h11, 32'h22, 32'h33};

    resetn = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    s_tdata = '0; s_tstrb = 4'hf; s_tkeep = 4'hf; s_tlast = 1'b0; s_tid = '0;
    s_tdest = 1'b1; s_tuser = 1'b1;
    b_s_tvalid = 1'b0; b_m_tready = 1'b0; b_s_tdata = 1'b1; b_s_tstrb = 1'b1;
    b_s_tkeep = 2'b00; b_s_tlast = 1'b0; b_s_tid = 1'b1; b_s_tdest = 1'b1; b_s_tuser = 1'b1;

    // reset state and release
    repeat (3) tick();
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    resetn = 1'b1;
    #1 check("rel_s_tready_pre", 64'(s_tready), 64'd0);
    tick();
    check("rel_s_tready", 64'(s_tready), 64'd1);
    check("rel_m_tvalid", 64'(m_tvalid), 64'd0);

    // test 1: streaming at full rate
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = t1v[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_valid", 64'(m_tvalid), 64'd1);
      check("t1_data", 64'(m_tdata), 64'(t1v[k]));
      check("t1_s_tready", 64'(s_tready), 64'd1);
      check("t1_dest_user", 64'({m_tdest, m_tuser}), 64'd0);
      if (k < 2) s_tdata = t1v[k+1];
      else s_tvalid = 1'b0;
    end
    tick();
    check("t1_drained", 64'(m_tvalid), 64'd0);

    // test 2: backpressure fills the skid register
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hA0;
    tick();
    check("t2_ready_one", 64'(s_tready), 64'd1);
    s_tdata = 32'hA1;
    tick();
    check("t2_ready_full", 64'(s_tready), 64'd0);
    check("t2_state_full", 64'(dbg_state), 64'd2);
    s_tdata = 32'hA2;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_hold_data", 64'(m_tdata), 64'hA0);
      check("t2_stall_ready", 64'(s_tready), 64'd0);
    end
    m_tready = 1'b1;
    tick();
    check("t2_second", 64'(m_tdata), 64'hA1);
    check("t2_ready_back", 64'(s_tready), 64'd1);
    tick();
    s_tvalid = 1'b0;
    check("t2_third", 64'(m_tdata), 64'hA2);
    tick();
    check("t2_drained", 64'(m_tvalid), 64'd0);

    // test 3: random valid/ready, scoreboard-checked
    nbeats = 0; cyc = 0; done = 1'b0;
    fork
      begin
        while (nbeats < 1000 && cyc < 20000) begin
          if (!s_tvalid) begin
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata  = $urandom;
            s_tkeep  = 4'($urandom_range(0, 15));
            s_tstrb  = s_tkeep;
            s_tlast  = ((nbeats % 8) == 7);
            s_tid    = 4'(nbeats);
          end
          @(negedge clk);
          took = s_tvalid && s_tready;
          tick();
          cyc++;
          if (took) begin
            nbeats++;
            s_tvalid = 1'b0;
          end
        end
        check("t3_beats", 64'(nbeats), 64'd1000);
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    s_tvalid = 1'b0; m_tready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("t3_drain", 64'(exp_q.size()), 64'd0);

    // test 4: asynchronous reset while FULL
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hC0; s_tlast = 1'b0; s_tid = '0;
    tick();
    s_tdata = 32'hC1;
    tick();
    s_tvalid = 1'b0;
    check("t4_full", 64'(dbg_state), 64'd2);
    #2 resetn = 1'b0;
    #1;
    check("t4_async_valid", 64'(m_tvalid), 64'd0);
    check("t4_async_ready", 64'(s_tready), 64'd0);
    check("t4_async_data", 64'(m_tdata), 64'd0);
    repeat (2) tick();
    resetn = 1'b1;
    #1 check("t4_rel_pre", 64'(s_tready), 64'd0);
    tick();
    check("t4_rel_ready", 64'(s_tready), 64'd1);
    m_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_no_stale", 64'(m_tvalid), 64'd0);
    end

    // test 5: byte_width=0 build passes keep/last, omitted fields read 0
    b_m_tready = 1'b1; b_s_tvalid = 1'b1; b_s_tkeep = 2'b10; b_s_tlast = 1'b1;
    tick();
    b_s_tvalid = 1'b0;
    check("t5_valid", 64'(b_m_tvalid), 64'd1);
    check("t5_keep", 64'(b_m_tkeep), 64'b10);
    check("t5_last", 64'(b_m_tlast), 64'd1);
    check("t5_zero_fields",
          64'({b_m_tdata, b_m_tstrb, b_m_tid, b_m_tdest, b_m_tuser}), 64'd0);
    tick();
    check("t5_drained", 64'(b_m_tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
